// File: rtl/dw_batch_if.sv
// Handshake bundle for dw_batch: sample input side and batch-result output side.
interface dw_batch_if #(
  parameter int W  = 16,
  parameter int CH = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        unit_error;
  logic [CH*W-1:0]     input_signal;
  logic                out_valid;
  logic                out_ready;
  logic [CH*W-1:0]     renew_parameter;
  logic [CH-1:0]       sat_flag;

  modport master (
    output in_valid, unit_error, input_signal, out_ready,
    input  in_ready, out_valid, renew_parameter, sat_flag
  );

  modport slave (
    input  in_valid, unit_error, input_signal, out_ready,
    output in_ready, out_valid, renew_parameter, sat_flag
  );
endinterface

// File: rtl/dw_batch.sv
// Batched weight-gradient stage: accumulates unit_error*input_signal over 2^BATCH_LOG2 samples
// and emits the saturated batch mean per channel. Define DW_ROUND_EN to round half toward +inf.
module dw_batch #(
  parameter int W          = 16,
  parameter int FRAC       = 10,
  parameter int CH         = 4,
  parameter int BATCH_LOG2 = 3
) (
  input  logic      clk,
  input  logic      res,
  input  logic      clr,
  dw_batch_if.slave bus
);

  localparam int AW = 2*W + BATCH_LOG2;
  localparam int SH = FRAC + BATCH_LOG2;
  localparam logic [BATCH_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [AW:0] MAXV = $signed({{(AW+1-W){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [AW:0] MINV = $signed({{(AW+1-W){1'b1}}, {(W-1){1'b0}}});
  localparam logic signed [AW:0] RND  = $signed({{AW{1'b0}}, 1'b1} << (SH-1));

  typedef enum logic [1:0] {ACC, SUM, FORM, OUT} state_t;

  state_t                  state;
  state_t                  next_state;
  logic [BATCH_LOG2-1:0]   cnt;
  logic                    prod_valid;
  logic signed [2*W-1:0]   prod [CH];
  logic signed [AW-1:0]    acc  [CH];
  logic                    out_valid;
  logic [CH*W-1:0]         renew_parameter;
  logic [CH-1:0]           sat_flag;
  logic [CH*W-1:0]         form_data;
  logic [CH-1:0]           form_sat;
  logic signed [AW:0]      ext;
  logic signed [AW:0]      shf;
  logic                    accept;

  assign bus.in_ready        = (state == ACC) & res;
  assign bus.out_valid       = out_valid;
  assign bus.renew_parameter = renew_parameter;
  assign bus.sat_flag        = sat_flag;
  assign accept              = bus.in_valid & bus.in_ready & ~clr;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= ACC;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ACC:     if (accept && cnt == CNT_LAST) next_state = SUM;
      SUM:     next_state = FORM;
      FORM:    next_state = OUT;
      OUT:     if (bus.out_ready) next_state = ACC;
      default: next_state = ACC;
    endcase
    if (clr) next_state = ACC;
  end

  // Scale the accumulator back to the Q format and clamp to W bits.
  always_comb begin
    form_data = '0;
    form_sat  = '0;
    ext       = '0;
    shf       = '0;
    for (int c = 0; c < CH; c++) begin
      ext = {acc[c][AW-1], acc[c]};
`ifdef DW_ROUND_EN
      ext = ext + RND;
`endif
      shf = ext >>> SH;
      if (shf > MAXV) begin
        form_data[c*W +: W] = MAXV[W-1:0];
        form_sat[c]         = 1'b1;
      end else if (shf < MINV) begin
        form_data[c*W +: W] = MINV[W-1:0];
        form_sat[c]         = 1'b1;
      end else begin
        form_data[c*W +: W] = shf[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt             <= '0;
      prod_valid      <= 1'b0;
      out_valid       <= 1'b0;
      renew_parameter <= '0;
      sat_flag        <= '0;
      for (int c = 0; c < CH; c++) begin
        prod[c] <= '0;
        acc[c]  <= '0;
      end
    end else if (clr) begin
      cnt        <= '0;
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else begin
      prod_valid <= accept;
      if (accept) begin
        cnt <= cnt + 1'b1;
        for (int c = 0; c < CH; c++)
          prod[c] <= $signed(bus.unit_error) * $signed(bus.input_signal[c*W +: W]);
      end
      if (state == OUT && bus.out_ready) begin
        out_valid <= 1'b0;
        cnt       <= '0;
        for (int c = 0; c < CH; c++) acc[c] <= '0;
      end else if (prod_valid) begin
        for (int c = 0; c < CH; c++)
          acc[c] <= acc[c] + {{BATCH_LOG2{prod[c][2*W-1]}}, prod[c]};
      end
      if (state == FORM) begin
        renew_parameter <= form_data;
        sat_flag        <= form_sat;
        out_valid       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dw_batch.sv
// Scoreboard bench for dw_batch: a reference model of the batch mean pushes expected results,
// the output monitor pops them on each result handshake.
module tb_dw_batch;

  localparam int W = 16;
  localparam int CH = 4;

  typedef struct {
    logic [CH*W-1:0] data;
    logic [CH-1:0]   sat;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  longint model_acc [CH];
  int   model_cnt = 0;

  dw_batch_if #(.W(W), .CH(CH)) bus ();

  dw_batch #(.W(W), .FRAC(10), .CH(CH), .BATCH_LOG2(3)) dut (
    .clk (clk),
    .res (res),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int c = 0; c < CH; c++) model_acc[c] = 0;
    model_cnt = 0;
  endtask

  task automatic modelAccept(input logic [15:0] ue, input logic [63:0] sig);
    exp_t   e;
    longint v;
    for (int c = 0; c < CH; c++) begin
      logic [15:0] x;
      x = sig[c*16 +: 16];
      model_acc[c] += longint'($signed(ue)) * longint'($signed(x));
    end
    model_cnt++;
    if (model_cnt == 8) begin
      e.data = '0;
      e.sat  = '0;
      for (int c = 0; c < CH; c++) begin
        v = model_acc[c];
`ifdef DW_ROUND_EN
        v = v + 4096;
`endif
        v = v >>> 13;
        if (v > 32767) begin v = 32767; e.sat[c] = 1'b1; end
        else if (v < -32768) begin v = -32768; e.sat[c] = 1'b1; end
        e.data[c*16 +: 16] = v[15:0];
      end
      q.push_back(e);
      modelClear();
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ue, input logic [63:0] sig, input int gap);
    int guard = 0;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checkOutput("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      bus.in_valid     = 1'b1;
      bus.unit_error   = ue;
      bus.input_signal = sig;
      modelAccept(ue, sig);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic waitOutValid(input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) checkOutput("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic setOutReady(input logic v);
    @(posedge clk);
    #1 bus.out_ready = v;
  endtask

  always @(negedge clk) begin
    if (res && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checkOutput("unexpected_out", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        checkOutput("renew_parameter", bus.renew_parameter, e.data);
        checkOutput("sat_flag", {60'd0, bus.sat_flag}, {60'd0, e.sat});
      end
    end
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.unit_error   = '0;
    bus.input_signal = '0;
    bus.out_ready    = 1'b1;
    modelClear();

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    checkOutput("rst_renew", bus.renew_parameter, 64'd0);
    checkOutput("rst_sat", {60'd0, bus.sat_flag}, 64'd0);
    @(posedge clk);
    #1 res = 1'b1;

    $display("[TB] basic mean and latency");
    for (int i = 0; i < 8; i++) applyStimulus(16'h0400, {4{16'h0200}}, 0);
    @(negedge clk);
    checkOutput("lat_e0", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    checkOutput("lat_e1", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    checkOutput("lat_e2", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("basic_value", bus.renew_parameter, {4{16'h0200}});
    @(negedge clk);
    checkOutput("post_hs_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("post_hs_ready", {63'd0, bus.in_ready}, 64'd1);

    $display("[TB] negative truncation");
    applyStimulus(16'hFFFF, 64'h0000_0000_0000_0001, 0);
    for (int i = 0; i < 7; i++) applyStimulus(16'h0000, 64'd0, 0);
    waitOutValid(10);

    $display("[TB] saturation");
    for (int i = 0; i < 8; i++) applyStimulus(16'h7FFF, 64'h0000_0000_8000_7FFF, 0);
    waitOutValid(10);
    checkOutput("sat_value", {60'd0, bus.sat_flag}, 64'd3);

    $display("[TB] bubbles and backpressure");
    setOutReady(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(16'h0400, {4{16'h0200}}, 1 + (i % 3));
    waitOutValid(10);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid     = (i % 2 == 0);
      bus.unit_error   = 16'h7FFF;
      bus.input_signal = {4{16'h7FFF}};
      checkOutput("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      checkOutput("bp_hold", bus.renew_parameter, q.size() > 0 ? q[0].data : 64'hX);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    setOutReady(1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(16'h0400, {4{16'h0100}}, 0);
    waitOutValid(10);

    $display("[TB] abort");
    for (int i = 0; i < 5; i++) applyStimulus(16'h0400, {4{16'h0400}}, 0);
    @(negedge clk);
    clr              = 1'b1;
    bus.in_valid     = 1'b1;
    bus.unit_error   = 16'h0400;
    bus.input_signal = {4{16'h0400}};
    modelClear();
    @(posedge clk);
    #1 clr = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(16'h0400, {4{16'h0100}}, 0);
    waitOutValid(10);
    checkOutput("abort_value", bus.renew_parameter, {4{16'h0100}});

    $display("[TB] async reset in OUT");
    setOutReady(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(16'h0400, {4{16'h0300}}, 0);
    waitOutValid(10);
    #2 res = 1'b0;
    #1;
    checkOutput("ares_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("ares_renew", bus.renew_parameter, 64'd0);
    checkOutput("ares_sat", {60'd0, bus.sat_flag}, 64'd0);
    checkOutput("ares_in_ready", {63'd0, bus.in_ready}, 64'd0);
    if (q.size() > 0) void'(q.pop_front());
    modelClear();
    @(posedge clk);
    #1 res = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(16'h0400, {4{16'h0200}}, 0);
    waitOutValid(10);

    repeat (4) @(negedge clk);
    checkOutput("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
